// File: rtl/tdc_capture_encoder.sv
// tdc_capture_encoder
//   Control and readout stage around a tapped delay line. Launches an edge
//   into the line and captures the thermometer code on the next clock. The
//   capture is synchronised and single-tap bubbles are removed. The result is
//   encoded to a binary tap count and handed downstream with valid/ready.
//
// Ports
//   clk_i    in   1      system clock
//   rst_ni   in   1      asynchronous active-low reset
//   start_i  in   1      request one measurement (sampled only in IDLE)
//   taps_i   in   N      thermometer taps from the delay line (async)
//   pulse_o  out  1      registered launch edge into the delay line
//   meas_o   out  OUT_W  corrected tap count, 0..N
//   ovf_o    out  1      all corrected taps set
//   zero_o   out  1      no corrected taps set
//   valid_o  out  1      meas_o/ovf_o/zero_o valid
//   ready_i  in   1      downstream accepts result
//   busy_o   out  1      FSM not in IDLE
module tdc_capture_encoder #(
  parameter  int unsigned N           = 64,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned DRAIN_CYC   = 4,
  localparam int unsigned OUT_W       = $clog2(N + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [N-1:0]     taps_i,
  output logic             pulse_o,
  output logic [OUT_W-1:0] meas_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  localparam int unsigned CNT_MAX = (SYNC_STAGES > DRAIN_CYC) ? SYNC_STAGES : DRAIN_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    VALID,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_d, valid_d, busy_d;
  logic             load_res;

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N+1:0]     t_ext;
  logic [N-1:0]     corr;
  logic [OUT_W-1:0] pop;

  // State register; pulse/valid/busy are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_o <= 1'b0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_o <= pulse_d;
      valid_o <= valid_d;
      busy_o  <= busy_d;
    end
  end

  // Next-state logic. The counter is loaded with (cycles - 1) on entry so
  // SETTLE lasts SYNC_STAGES cycles and DRAIN lasts DRAIN_CYC cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = SETTLE;
        cnt_d   = CNT_W'(SYNC_STAGES - 1);
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = VALID;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      VALID: begin
        if (ready_i) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from state_d.
  always_comb begin
    pulse_d  = (state_d == LAUNCH) || (state_d == SETTLE) || (state_d == VALID);
    valid_d  = (state_d == VALID);
    busy_d   = (state_d != IDLE);
    load_res = (state_q == SETTLE) && (cnt_q == '0);
  end

  // Capture flop loads only in LAUNCH; later stages shift every edge, which
  // is harmless since stage 0 is frozen until the next launch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
    end else begin
      if (state_q == LAUNCH) sync_q[0] <= taps_i;
      for (int unsigned j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
    end
  end

  // Bubble correction: 3-tap majority with the line start tied to 1 and the
  // far end tied to 0, then popcount.
  always_comb begin
    t_ext = {1'b0, sync_q[SYNC_STAGES-1], 1'b1};
    corr  = '0;
    pop   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      corr[i] = (t_ext[i] & t_ext[i+1]) | (t_ext[i] & t_ext[i+2]) | (t_ext[i+1] & t_ext[i+2]);
      pop     = pop + OUT_W'(corr[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meas_o <= '0;
      ovf_o  <= 1'b0;
      zero_o <= 1'b0;
    end else if (load_res) begin
      meas_o <= pop;
      ovf_o  <= (pop == OUT_W'(N));
      zero_o <= (pop == '0);
    end
  end

endmodule

// File: tb/tb_tdc_capture_encoder.sv
module tb_tdc_capture_encoder;

  localparam int unsigned N     = 64;
  localparam int unsigned OUT_W = $clog2(N + 1);

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [N-1:0]     taps_i = '0;
  logic             pulse_o;
  logic [OUT_W-1:0] meas_o;
  logic             ovf_o;
  logic             zero_o;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic             busy_o;

  typedef struct {
    logic [OUT_W-1:0] meas;
    logic             ovf;
    logic             zero;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  tdc_capture_encoder #(
    .N(N),
    .SYNC_STAGES(2),
    .DRAIN_CYC(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start_i),
    .taps_i (taps_i),
    .pulse_o(pulse_o),
    .meas_o (meas_o),
    .ovf_o  (ovf_o),
    .zero_o (zero_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: compares every accepted result against the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(valid_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("meas", 64'(meas_o), 64'(e.meas));
        chk("ovf",  64'(ovf_o),  64'(e.ovf));
        chk("zero", 64'(zero_o), 64'(e.zero));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 50) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy_o), 64'd0);
  endtask

  // Waits for valid_o; returns cycles counted from the launch edge.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid_o && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_meas(input logic [N-1:0] taps, input logic [OUT_W-1:0] m,
                          input logic o, input logic z);
    int cyc;
    exp_t e;
    wait_idle();
    e.meas = m; e.ovf = o; e.zero = z;
    sb.push_back(e);
    taps_i  = taps;
    start_i = 1'b1;
    tick();                          // edge k
    chk("launch_pulse", 64'(pulse_o), 64'd1);
    chk("launch_busy",  64'(busy_o),  64'd1);
    start_i = 1'b0;
    wait_valid(cyc);
    chk("latency", 64'(cyc), 64'd3);
  endtask

  initial begin
    int cyc;
    logic [OUT_W-1:0] held;

    // Reset values
    tick();
    tick();
    chk("rst_pulse", 64'(pulse_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy",  64'(busy_o),  64'd0);
    chk("rst_meas",  64'(meas_o),  64'd0);
    rst_ni = 1'b1;
    tick();

    // Directed patterns
    run_meas(64'h0000_0000_0000_00FF, 7'd8,  1'b0, 1'b0);
    run_meas(64'h0000_0000_0000_0FDF, 7'd12, 1'b0, 1'b0);
    run_meas(64'h0000_0000_0001_00FF, 7'd8,  1'b0, 1'b0);
    run_meas('1,                      7'd64, 1'b1, 1'b0);
    run_meas('0,                      7'd0,  1'b0, 1'b1);
    run_meas(64'h0000_0000_0000_0001, 7'd1,  1'b0, 1'b0);
    run_meas(64'h7FFF_FFFF_FFFF_FFFF, 7'd63, 1'b0, 1'b0);

    // Backpressure with ignored start pulses
    wait_idle();
    ready_i = 1'b0;
    run_meas(64'h0000_0000_FFFF_FFFF, 7'd32, 1'b0, 1'b0);
    held = meas_o;
    for (int i = 0; i < 10; i++) begin
      start_i = (i % 3 == 0);
      tick();
      chk("bp_valid", 64'(valid_o), 64'd1);
      chk("bp_meas",  64'(meas_o),  64'(held));
      chk("bp_pulse", 64'(pulse_o), 64'd1);
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    tick();                          // handshake edge -> DRAIN
    chk("drain_valid", 64'(valid_o), 64'd0);
    chk("drain_pulse", 64'(pulse_o), 64'd0);
    chk("drain_meas",  64'(meas_o),  64'(held));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_busy", 64'(busy_o), 64'd1);
    end
    tick();
    chk("drain_done", 64'(busy_o), 64'd0);

    // Reset during SETTLE: no result, then normal operation
    taps_i  = 64'h0000_0000_0000_FFFF;
    start_i = 1'b1;
    tick();                          // LAUNCH
    start_i = 1'b0;
    tick();                          // SETTLE
    rst_ni = 1'b0;
    #1;
    chk("midrst_pulse", 64'(pulse_o), 64'd0);
    chk("midrst_busy",  64'(busy_o),  64'd0);
    chk("midrst_meas",  64'(meas_o),  64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_valid", 64'(valid_o), 64'd0);
    end
    rst_ni = 1'b1;
    tick();
    run_meas(64'h0000_0000_0000_03FF, 7'd10, 1'b0, 1'b0);

    // Back-to-back with start held high
    wait_idle();
    begin
      exp_t e;
      e.meas = 7'd16; e.ovf = 1'b0; e.zero = 1'b0;
      sb.push_back(e);
      sb.push_back(e);
    end
    taps_i  = 64'h0000_0000_0000_FFFF;
    start_i = 1'b1;
    wait_valid(cyc);
    tick();
    wait_valid(cyc);
    chk("b2b_gap", 64'(cyc), 64'd8);  // 4 drain + 1 idle + 3 latency
    tick();
    start_i = 1'b0;

    // Drain the scoreboard
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
